// File: rtl/alu_seq_pkg.sv
// Shared types for the alu_seq block: opcode encoding, handshake FSM states
// and the opcode field width.
package alu_seq_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_XOR  = 4'b0010,
        OP_SLT  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_NAND = 4'b0101,
        OP_NOR  = 4'b0110,
        OP_OR   = 4'b0111,
        OP_MUL  = 4'b1000
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Only instantiated by alu_seq when ALU_SEQ_MUL_EN is defined.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CW-1:0]      cnt_r;
    logic               done_r;

    // Load on start, then add the shifted multiplicand for each set multiplier bit;
    // done pulses on the edge that retires the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            done_r   <= 1'b0;
        end else if (start) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= CW'(WIDTH);
            done_r   <= 1'b0;
        end else if (cnt_r != {CW{1'b0}}) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r - CW'(1);
            done_r   <= (cnt_r == CW'(1));
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign done    = done_r;
    assign product = acc_r;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops complete in one edge.
// Define ALU_SEQ_MUL_EN to include the iterative multiplier (op 1000), else it is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic              cout,
    output logic              overflow,
    output logic              zero,
    output logic              err
);

    state_e             state_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   result_hi_r;
    logic               cout_r;
    logic               overflow_r;
    logic               zero_r;
    logic               err_r;

    logic               accept_s;
    logic               is_mul_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;
    logic [WIDTH-1:0]   res_s;
    logic               cout_s;
    logic               ovf_s;
    logic               err_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] product_s;

    assign in_ready = (state_r == IDLE) || ((state_r == HOLD) && out_ready);
    assign accept_s = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    alu_seq_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s && is_mul_s),
        .a       (a),
        .b       (b),
        .done    (mul_done_s),
        .product (product_s)
    );
`else
    assign mul_done_s = 1'b0;
    assign product_s  = {(2*WIDTH){1'b0}};
`endif

    // Single-cycle datapath; SLT uses sign-of-difference corrected by overflow.
    always_comb begin
        sum_s     = {1'b0, a} + {1'b0, b};
        diff_s    = {1'b0, a} - {1'b0, b};
        add_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        sub_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
        res_s     = {WIDTH{1'b0}};
        cout_s    = 1'b0;
        ovf_s     = 1'b0;
        err_s     = 1'b0;
        is_mul_s  = 1'b0;
        case (op)
            OP_ADD: begin
                res_s  = sum_s[WIDTH-1:0];
                cout_s = sum_s[WIDTH];
                ovf_s  = add_ovf_s;
            end
            OP_SUB: begin
                res_s  = diff_s[WIDTH-1:0];
                cout_s = diff_s[WIDTH];
                ovf_s  = sub_ovf_s;
            end
            OP_XOR:  res_s = a ^ b;
            OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ sub_ovf_s};
            OP_AND:  res_s = a & b;
            OP_NAND: res_s = ~(a & b);
            OP_NOR:  res_s = ~(a | b);
            OP_OR:   res_s = a | b;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL:  is_mul_s = 1'b1;
`else
            OP_MUL:  err_s = 1'b1;
`endif
            default: err_s = 1'b1;
        endcase
    end

    // Handshake FSM with registered result/flags. Illegal ops report only err,
    // so zero stays low for them even though result is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            cout_r      <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (accept_s && is_mul_s) begin
            state_r     <= BUSY;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            state_r     <= HOLD;
            out_valid_r <= 1'b1;
            result_r    <= res_s;
            result_hi_r <= {WIDTH{1'b0}};
            cout_r      <= cout_s;
            overflow_r  <= ovf_s;
            zero_r      <= !err_s && (res_s == {WIDTH{1'b0}});
            err_r       <= err_s;
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                BUSY: begin
                    if (mul_done_s) begin
                        state_r     <= HOLD;
                        out_valid_r <= 1'b1;
                        result_r    <= product_s[WIDTH-1:0];
                        result_hi_r <= product_s[2*WIDTH-1:WIDTH];
                        cout_r      <= 1'b0;
                        overflow_r  <= (product_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
                        zero_r      <= (product_s[WIDTH-1:0] == {WIDTH{1'b0}});
                        err_r       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
`ifdef ALU_SEQ_MUL_EN
    assign result_hi = result_hi_r;
`else
    assign result_hi = {WIDTH{1'b0}};
`endif
    assign cout      = cout_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;
    assign err       = err_r;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  request valid; a, b, op sampled on clk edge when in_valid && in_ready.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  4  opcode: 0000 ADD, 0001 SUB, 0010 XOR, 0011 SLT, 0100 AND, 0101 NAND, 0110 NOR, 0111 OR, 1000 MUL; all others illegal.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result/flags valid; held until out_valid && out_ready.
REQ-009 out_ready  input  1  consumer accepts result this cycle.
REQ-010 result  output  WIDTH  result (low half for MUL).
REQ-011 result_hi  output  WIDTH  upper product half for MUL, else 0.
REQ-012 cout, overflow, zero, err  output  1 each  carry/borrow, signed overflow, result==0, illegal/disabled op.

Function
REQ-013 FSM states IDLE, BUSY, HOLD; IDLE->HOLD on accepted single-cycle op, IDLE->BUSY on accepted MUL, BUSY->HOLD when multiplier done, HOLD->IDLE on out_ready with no new accept, HOLD->HOLD/BUSY on out_ready with simultaneous accept.
REQ-014 in_ready = (state==IDLE) || (state==HOLD && out_ready); in_ready SHALL be 0 in BUSY.
REQ-015 Single-cycle ops: out_valid asserted on the clk edge that accepts the request (latency 1); back-to-back throughput one op per cycle when out_ready held 1.
REQ-016 MUL: unsigned WIDTH x WIDTH, shift-add one bit per cycle; out_valid rises exactly WIDTH+1 cycles after accept.
REQ-017 result, result_hi and flags SHALL be stable while out_valid && !out_ready.
REQ-018 ADD: result = (a+b) mod 2^WIDTH; cout = carry out of MSB; overflow = signed overflow.
REQ-019 SUB: result = (a-b) mod 2^WIDTH; cout = 1 iff a < b unsigned (borrow); overflow = signed overflow.
REQ-020 SLT: result = 1 iff a < b signed, correct including operand pairs whose difference overflows; cout=overflow=0.
REQ-021 Logic ops: bitwise per opcode; cout=overflow=0.
REQ-022 MUL: {result_hi,result} = a*b; overflow = (result_hi != 0); cout=0.
REQ-023 zero = (result == 0) for every op (result_hi ignored).
REQ-024 Illegal op: accepted, latency 1, result=result_hi=0, err=1, other flags 0; err=0 for legal ops.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, out_valid=0, result=result_hi=0, all flags 0, multiplier cleared; in_ready=1 after release.
REQ-026 Reset during BUSY or HOLD SHALL discard the in-flight operation with no result emitted.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: defined -> MUL and sub-module present as above; undefined -> no multiplier logic, BUSY unreachable, op 1000 treated as illegal (REQ-024), result_hi tied 0.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum and opcode width constant.
REQ-029 Sub-module alu_seq_mul (start, a, b -> done, product[2*WIDTH]) SHALL hold the iterative multiplier, instantiated only under ALU_SEQ_MUL_EN.

Verification
REQ-030 WIDTH=32, ADD a=0xFFFFFFFF b=1 -> result 0, cout=1, overflow=0, zero=1, out_valid next cycle.
REQ-031 SUB a=0x80000000 b=0x40000000 -> result 0x40000000, overflow=1; SLT same operands -> result 1.
REQ-032 MUL (macro on) a=0xFFFFFFFF b=2 -> result 0xFFFFFFFE, result_hi 1, overflow=1, out_valid 33 cycles after accept, in_ready=0 throughout BUSY.
REQ-033 out_ready=0 for 5 cycles after XOR a=0xF0 b=0xFF -> result 0x0F held stable, in_ready=0; out_ready=1 with new ADD accepted same cycle -> next result 1 cycle later.
REQ-034 rst_n pulsed low mid-MUL -> out_valid 0 immediately, no result emitted, in_ready=1 after release; macro off, op 1000 -> err=1, result 0.
REQ-035 WIDTH=8 sweep all 65536 operand pairs for ADD/SUB/SLT against behavioural model.
